row_scanout: RTL

//  Video scan-out stage between the read port of the active grid BRAM and the pixel packer.

---
 rtl/gol_pkg.sv | 13 +
 rtl/row_prefetch_ctrl.sv | 70 +++++++
 rtl/row_scanout.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/gol_pkg.sv
// Shared constants and scan-out state encoding for the grid video path.
package gol_pkg;

    localparam int          X_SIZE    = 1280;
    localparam int          Y_SIZE    = 720;
    localparam int          X_WIDTH   = $clog2(X_SIZE);
    localparam int          Y_WIDTH   = $clog2(Y_SIZE);
    localparam logic [23:0] ALIVE_RGB = 24'hCB416B;
    localparam logic [23:0] DEAD_RGB  = 24'h000000;

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, STALL} scan_state_t;

endpackage

// File: rtl/row_prefetch_ctrl.sv
// Tracks outstanding BRAM reads through the read-latency delay line and owns
// the active/next row double buffer.
module row_prefetch_ctrl #(
    parameter int X_SIZE     = 1280,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              issue_active,
    input  logic              swap,
    input  logic [X_SIZE-1:0] row_data,
    output logic [X_SIZE-1:0] active_row,
    output logic [X_SIZE-1:0] next_row,
    output logic              next_ok,
    output logic              cap_active
);

    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic                  tgt_active_q, tgt_active_d;
    logic [X_SIZE-1:0]     active_q, active_d;
    logic [X_SIZE-1:0]     next_q, next_d;
    logic                  next_ok_q, next_ok_d;
    logic                  cap, cap_next;

    // Only one read is ever in flight, so a single target flag suffices.
    assign cap        = vld_pipe_q[RD_LATENCY-1];
    assign cap_active = cap && tgt_active_q;
    assign cap_next   = cap && !tgt_active_q;

    always_comb begin
        vld_pipe_d   = (vld_pipe_q << 1) | RD_LATENCY'(issue);
        tgt_active_d = issue ? issue_active : tgt_active_q;
        active_d     = active_q;
        next_d       = next_q;
        next_ok_d    = next_ok_q;
        if (cap_active) begin
            active_d = row_data;
        end else if (swap) begin
            active_d = next_q;
        end
        if (cap_next) begin
            next_d    = row_data;
            next_ok_d = 1'b1;
        end else if (swap) begin
            next_ok_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q   <= '0;
            tgt_active_q <= 1'b0;
            active_q     <= '0;
            next_q       <= '0;
            next_ok_q    <= 1'b0;
        end else begin
            vld_pipe_q   <= vld_pipe_d;
            tgt_active_q <= tgt_active_d;
            active_q     <= active_d;
            next_q       <= next_d;
            next_ok_q    <= next_ok_d;
        end
    end

    assign active_row = active_q;
    assign next_row   = next_q;
    assign next_ok    = next_ok_q;

endmodule

// File: rtl/row_scanout.sv
// Grid row scan-out: fetches rows from BRAM (next row prefetched) and streams
// one coloured pixel per accepted beat to the packer.
module row_scanout #(
    parameter int          X_SIZE     = gol_pkg::X_SIZE,
    parameter int          Y_SIZE     = gol_pkg::Y_SIZE,
    parameter int          RD_LATENCY = 2,
    parameter logic [23:0] ALIVE_RGB  = gol_pkg::ALIVE_RGB,
    parameter logic [23:0] DEAD_RGB   = gol_pkg::DEAD_RGB
) (
    input  logic                      out_stream_aclk,
    input  logic                      periph_reset,
    input  logic                      enable,
    output logic                      row_en,
    output logic [$clog2(Y_SIZE)-1:0] row_addr,
    input  logic [X_SIZE-1:0]         row_data,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [7:0]                r,
    output logic [7:0]                g,
    output logic [7:0]                b,
    output logic                      sof,
    output logic                      eol,
    output logic                      frame_done,
    output logic                      busy
);

    localparam int XW = $clog2(X_SIZE);
    localparam int YW = $clog2(Y_SIZE);
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    import gol_pkg::*;

    scan_state_t       state_q, state_d;
    logic [XW-1:0]     x_q, x_d, x_nxt;
    logic [YW-1:0]     y_q, y_d;
    logic              pix_valid_q, pix_valid_d;
    logic [23:0]       rgb_q, rgb_d;
    logic              sof_q, sof_d, eol_q, eol_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              row_en_q, row_en_d;
    logic [YW-1:0]     row_addr_q, row_addr_d;
    logic              accept, swap;
    logic [X_SIZE-1:0] active_row, next_row;
    logic              next_ok, cap_active;

    function automatic logic [23:0] cell_colour(input logic alive);
        return alive ? ALIVE_RGB : DEAD_RGB;
    endfunction

    row_prefetch_ctrl #(
        .X_SIZE     (X_SIZE),
        .RD_LATENCY (RD_LATENCY)
    ) u_prefetch (
        .clk          (out_stream_aclk),
        .rst          (periph_reset),
        .issue        (row_en_q),
        .issue_active (state_q == FETCH),
        .swap         (swap),
        .row_data     (row_data),
        .active_row   (active_row),
        .next_row     (next_row),
        .next_ok      (next_ok),
        .cap_active   (cap_active)
    );

    assign accept = pix_valid_q && pix_ready;
    assign x_nxt  = x_q + XW'(1);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        pix_valid_d  = pix_valid_q;
        rgb_d        = rgb_q;
        sof_d        = sof_q;
        eol_d        = eol_q;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        row_en_d     = 1'b0;
        row_addr_d   = row_addr_q;
        swap         = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d    = FETCH;
                    row_en_d   = 1'b1;
                    row_addr_d = '0;
                    busy_d     = 1'b1;
                    x_d        = '0;
                    y_d        = '0;
                end
            end
            FETCH: begin
                if (cap_active) state_d = STREAM;
            end
            STREAM: begin
                if (!pix_valid_q) begin
                    // Entry from FETCH/STALL: present pixel x of the active row.
                    pix_valid_d = 1'b1;
                    rgb_d       = cell_colour(active_row[X_LAST - x_q]);
                    sof_d       = (x_q == '0) && (y_q == '0);
                    eol_d       = (x_q == X_LAST);
                end else if (accept) begin
                    if (x_q == '0 && y_q != Y_LAST) begin
                        row_en_d   = 1'b1;
                        row_addr_d = y_q + YW'(1);
                    end
                    if (eol_q) begin
                        x_d         = '0;
                        pix_valid_d = 1'b0;
                        sof_d       = 1'b0;
                        eol_d       = 1'b0;
                        rgb_d       = '0;
                        if (y_q == Y_LAST) begin
                            frame_done_d = 1'b1;
                            y_d          = '0;
                            if (enable) begin
                                state_d    = FETCH;
                                row_en_d   = 1'b1;
                                row_addr_d = '0;
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            y_d = y_q + YW'(1);
                            if (next_ok) begin
                                // Present pixel 0 of the prefetched row straight away.
                                swap        = 1'b1;
                                pix_valid_d = 1'b1;
                                rgb_d       = cell_colour(next_row[X_LAST]);
                                eol_d       = (X_LAST == '0);
                            end else begin
                                state_d = STALL;
                            end
                        end
                    end else begin
                        x_d   = x_nxt;
                        rgb_d = cell_colour(active_row[X_LAST - x_nxt]);
                        sof_d = 1'b0;
                        eol_d = (x_nxt == X_LAST);
                    end
                end
            end
            STALL: begin
                if (next_ok) begin
                    swap    = 1'b1;
                    state_d = STREAM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            pix_valid_q  <= 1'b0;
            rgb_q        <= '0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            row_en_q     <= 1'b0;
            row_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pix_valid_q  <= pix_valid_d;
            rgb_q        <= rgb_d;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            row_en_q     <= row_en_d;
            row_addr_q   <= row_addr_d;
        end
    end

    assign row_en     = row_en_q;
    assign row_addr   = row_addr_q;
    assign pix_valid  = pix_valid_q;
    assign r          = rgb_q[23:16];
    assign g          = rgb_q[15:8];
    assign b          = rgb_q[7:0];
    assign sof        = sof_q;
    assign eol        = eol_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
